filter_window: RTL and testbench
================================

# filter_window

Builds a 3x3 pixel neighbourhood from three row-aligned pixel streams and presents one complete window per beat to the filter kernel. Sits directly downstream of two cascaded `delay_mem` row buffers: the live stream plus the one-row-delayed and two-row-delayed streams enter together. The block tracks column and row position within the frame and emits a window only when all nine pixels lie inside the image, i.e. no border padding. It flags the start of frame, end of each output row, and end of frame for the kernel.

## Interface
- `IMG_WIDTH`, 8, bits per pixel
- `DIM_WIDTH`, 12, width of the column and row counters and config fields
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset); one clock, reset is asynchronous and active-low
- `cfg_cols` in DIM_WIDTH: image width in pixels
- `cfg_rows` in DIM_WIDTH: image height in rows
- `cfg_set` in 1: one-cycle strobe that loads `cfg_cols`/`cfg_rows` and restarts the frame
- `up_row0` in IMG_WIDTH: live pixel, current row r
- `up_row1` in IMG_WIDTH: same column, row r-1
- `up_row2` in IMG_WIDTH: same column, row r-2
- `up_val` in 1: all three up_row inputs valid this cycle; no backpressure
- `dn_win` out 9*IMG_WIDTH: window, element k=3*i+j at bits [IMG_WIDTH*k +: IMG_WIDTH]; i=0 oldest row (r-2), j=0 oldest column (c-2)
- `dn_val` out 1: dn_win valid, one-cycle pulse per window
- `dn_sof` out 1: qualifies the first window of a frame
- `dn_eol` out 1: qualifies the last window of an output row
- `dn_eof` out 1: qualifies the last window of a frame
- `cfg_err` out 1: latched when the last cfg_set had cols<3 or rows<3

## Operation
- States: IDLE (unconfigured or bad config; up_val ignored) and RUN.
- cfg_set in any state:
  - Registers the config.
  - Clears col/row counters and the window registers.
  - Next state is RUN if cols>=3 and rows>=3 (cfg_err<=0); otherwise IDLE (cfg_err<=1).
- In RUN, on each up_val:
  - Shift the window one column: column j=0 takes old j=1, j=1 takes old j=2, j=2 takes {up_row2, up_row1, up_row0} as rows i=0,1,2.
  - Column counter `col` counts 0..cols-1 and wraps to 0. On wrap, row counter `row` increments through 0..rows-1 and wraps to 0, which starts the next frame with no re-config.
- A window is emitted when the accepting beat has col>=2 and row>=2. The centre pixel is (row-1, col-1).
- Flags, evaluated on the emitting beat:
  - dn_sof: col==2 and row==2.
  - dn_eol: col==cols-1.
  - dn_eof: col==cols-1 and row==rows-1.
- Windows per frame: (cols-2)*(rows-2), with cols-2 per output row.
- Window registers shift on every accepted beat, including non-emitting ones; contents carried across a row wrap are flushed by the col>=2 rule.
- Counter compares use DIM_WIDTH-bit unsigned arithmetic. cols/rows up to 2^DIM_WIDTH-1 are legal.

## Timing
- Reset (rst=0) forces:
  - dn_val, dn_sof, dn_eol, dn_eof, cfg_err, dn_win to 0.
  - state to IDLE; counters to 0.
  - A new cfg_set is required after reset, including reset mid-frame.
- Latency: dn_win/dn_val/flags are registered and appear the cycle after the up_val beat that completes the window.
- dn_val is 0 on every cycle without an emitting beat. dn_win holds its last value when dn_val=0.
- cfg_set and up_val in the same cycle: cfg_set wins and that pixel beat is dropped. dn_val is 0 the following cycle.
- The first beat accepted after cfg_set may arrive the very next cycle. It is col 0, row 0.
- Back-to-back up_val every cycle sustains one window per cycle. Gaps in up_val stall the counters and window without loss.
- up_val in IDLE: no counter change, no output.

## Test plan
- cfg 4x4, full-rate stream, pixel (r,c) = 16r+c on up_row0, up_row1 = 16(r-1)+c, up_row2 = 16(r-2)+c (0 when r<2):
  - exactly 4 dn_val pulses;
  - first window k=0..8 = 0x00,01,02,10,11,12,20,21,22 with dn_sof=1;
  - dn_eol on windows 2 and 4;
  - dn_eof only on window 4, centre 0x22.
- Same 4x4 frame with up_val toggling 1/0 every cycle: identical window sequence and flags. Each dn_val follows its completing beat by exactly one cycle.
- cfg 5x3, two frames back-to-back with no cfg_set between: 3 windows per frame, dn_sof on windows 1 and 4, dn_eof on windows 3 and 6.
- cfg_set with cols=2 rows=8: cfg_err=1, state IDLE, 20 up_val beats produce no dn_val. cfg_set with cols=3 rows=3: cfg_err=0, 9 beats produce exactly 1 window with sof, eol and eof all set.
- 4x4 frame, assert cfg_set together with the beat at row 2 col 1: that beat is dropped. The next beat is treated as (0,0) and no dn_val appears until the new frame's row 2 col 2.
- Pull rst low mid-frame for one cycle, asynchronously, between clock edges: all outputs go to 0 immediately. Later up_val beats produce nothing until cfg_set, after which a 4x4 frame yields 4 windows.

Source files
------------

// File: rtl/filter_window.sv
// 3x3 window builder for three row-aligned pixel streams.
// Emits only fully interior windows and tags start of frame, end of row and end of frame.
module filter_window #(
    parameter int unsigned IMG_WIDTH = 8,
    parameter int unsigned DIM_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIM_WIDTH-1:0]   cfg_cols,
    input  logic [DIM_WIDTH-1:0]   cfg_rows,
    input  logic                   cfg_set,
    input  logic [IMG_WIDTH-1:0]   up_row0,
    input  logic [IMG_WIDTH-1:0]   up_row1,
    input  logic [IMG_WIDTH-1:0]   up_row2,
    input  logic                   up_val,
    output logic [9*IMG_WIDTH-1:0] dn_win,
    output logic                   dn_val,
    output logic                   dn_sof,
    output logic                   dn_eol,
    output logic                   dn_eof,
    output logic                   cfg_err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   cols_q, cols_d;
    logic [DIM_WIDTH-1:0]   rows_q, rows_d;
    logic [DIM_WIDTH-1:0]   col_q, col_d;
    logic [DIM_WIDTH-1:0]   row_q, row_d;
    logic [IMG_WIDTH-1:0]   win_q [9];
    logic [IMG_WIDTH-1:0]   win_d [9];
    logic [IMG_WIDTH-1:0]   win_shift [9];
    logic [IMG_WIDTH-1:0]   row_in [3];
    logic [9*IMG_WIDTH-1:0] dn_win_q, dn_win_d;
    logic                   dn_val_q, dn_val_d;
    logic                   dn_sof_q, dn_sof_d;
    logic                   dn_eol_q, dn_eol_d;
    logic                   dn_eof_q, dn_eof_d;
    logic                   cfg_err_q, cfg_err_d;

    logic cfg_ok;
    logic accept;
    logic emit;
    logic col_last;
    logic row_last;

    // Row index i of the window: 0 is the oldest row (r-2), 2 is the live row.
    assign row_in[0] = up_row2;
    assign row_in[1] = up_row1;
    assign row_in[2] = up_row0;

    assign cfg_ok   = (cfg_cols >= DIM_WIDTH'(3)) && (cfg_rows >= DIM_WIDTH'(3));
    assign accept   = (state_q == StRun) && up_val && !cfg_set;
    assign col_last = (col_q == cols_q - DIM_WIDTH'(1));
    assign row_last = (row_q == rows_q - DIM_WIDTH'(1));
    assign emit     = accept && (col_q >= DIM_WIDTH'(2)) && (row_q >= DIM_WIDTH'(2));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_shift[3*i]     = win_q[3*i+1];
            win_shift[3*i + 1] = win_q[3*i+2];
            win_shift[3*i + 2] = row_in[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        rows_d    = rows_q;
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        dn_win_d  = dn_win_q;
        dn_val_d  = 1'b0;
        dn_sof_d  = 1'b0;
        dn_eol_d  = 1'b0;
        dn_eof_d  = 1'b0;
        cfg_err_d = cfg_err_q;

        if (cfg_set) begin
            // A pixel arriving with cfg_set is dropped; the next beat is (0,0).
            cols_d    = cfg_cols;
            rows_d    = cfg_rows;
            col_d     = '0;
            row_d     = '0;
            for (int k = 0; k < 9; k++) begin
                win_d[k] = '0;
            end
            state_d   = cfg_ok ? StRun : StIdle;
            cfg_err_d = !cfg_ok;
        end else if (accept) begin
            win_d = win_shift;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + DIM_WIDTH'(1);
            end else begin
                col_d = col_q + DIM_WIDTH'(1);
            end
            if (emit) begin
                dn_val_d = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    dn_win_d[IMG_WIDTH*k +: IMG_WIDTH] = win_shift[k];
                end
                dn_sof_d = (col_q == DIM_WIDTH'(2)) && (row_q == DIM_WIDTH'(2));
                dn_eol_d = col_last;
                dn_eof_d = col_last && row_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cols_q    <= '0;
            rows_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
            dn_win_q  <= '0;
            dn_val_q  <= 1'b0;
            dn_sof_q  <= 1'b0;
            dn_eol_q  <= 1'b0;
            dn_eof_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cols_q    <= cols_d;
            rows_q    <= rows_d;
            col_q     <= col_d;
            row_q     <= row_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
            end
            dn_win_q  <= dn_win_d;
            dn_val_q  <= dn_val_d;
            dn_sof_q  <= dn_sof_d;
            dn_eol_q  <= dn_eol_d;
            dn_eof_q  <= dn_eof_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign dn_win  = dn_win_q;
    assign dn_val  = dn_val_q;
    assign dn_sof  = dn_sof_q;
    assign dn_eol  = dn_eol_q;
    assign dn_eof  = dn_eof_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_filter_window.sv
// Directed bench for filter_window: pixel (r,c) carries value 16r+c so every
// window element can be predicted from its position.
module tb_filter_window;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] cfg_cols = '0;
    logic [11:0] cfg_rows = '0;
    logic        cfg_set = 1'b0;
    logic [7:0]  up_row0 = '0;
    logic [7:0]  up_row1 = '0;
    logic [7:0]  up_row2 = '0;
    logic        up_val = 1'b0;
    logic [71:0] dn_win;
    logic        dn_val;
    logic        dn_sof;
    logic        dn_eol;
    logic        dn_eof;
    logic        cfg_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    // Captured output windows.
    int          ev_n = 0;
    logic [71:0] ev_win [256];
    logic        ev_sof [256];
    logic        ev_eol [256];
    logic        ev_eof [256];
    int          ev_cyc [256];

    // Cycles of the beats expected to complete a window in the last frame sent.
    int exp_cyc [64];
    int exp_cnt;

    filter_window #(
        .IMG_WIDTH(8),
        .DIM_WIDTH(12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_cols(cfg_cols),
        .cfg_rows(cfg_rows),
        .cfg_set (cfg_set),
        .up_row0 (up_row0),
        .up_row1 (up_row1),
        .up_row2 (up_row2),
        .up_val  (up_val),
        .dn_win  (dn_win),
        .dn_val  (dn_val),
        .dn_sof  (dn_sof),
        .dn_eol  (dn_eol),
        .dn_eof  (dn_eof),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dn_val === 1'b1) begin
            if (ev_n < 256) begin
                ev_win[ev_n] <= dn_win;
                ev_sof[ev_n] <= dn_sof;
                ev_eol[ev_n] <= dn_eol;
                ev_eof[ev_n] <= dn_eof;
                ev_cyc[ev_n] <= cyc;
            end
            ev_n <= ev_n + 1;
        end
    end

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[8*(3*i+j) +: 8] = 8'(16*(r-2+i) + (c-2+j));
            end
        end
        return w;
    endfunction

    // One clock cycle of stimulus; returns at posedge+1.
    task automatic drive(input bit v, input bit cs, input int r, input int c);
        up_val  = v;
        cfg_set = cs;
        up_row0 = 8'(16*r + c);
        up_row1 = (r >= 1) ? 8'(16*(r-1) + c) : 8'h00;
        up_row2 = (r >= 2) ? 8'(16*(r-2) + c) : 8'h00;
        @(posedge clk);
        #1;
        up_val  = 1'b0;
        cfg_set = 1'b0;
    endtask

    task automatic do_cfg(input int cols, input int rows);
        cfg_cols = 12'(cols);
        cfg_rows = 12'(rows);
        drive(1'b0, 1'b1, 0, 0);
    endtask

    task automatic send_frame(input int rows, input int cols, input bit toggle);
        exp_cnt = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                drive(1'b1, 1'b0, r, c);
                if (r >= 2 && c >= 2) begin
                    exp_cyc[exp_cnt] = cyc;
                    exp_cnt++;
                end
                if (toggle) drive(1'b0, 1'b0, 0, 0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(2);
        chk_cnt++;
        if ({dn_val, dn_sof, dn_eol, dn_eof, cfg_err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {dn_val, dn_sof, dn_eol, dn_eof, cfg_err});
        else pass_cnt++;
        chk_cnt++;
        if (dn_win !== 72'h0) $display("FAIL reset_win: got %h want 0", dn_win);
        else pass_cnt++;
        rst = 1'b1;
        idle(1);
        // Unconfigured after reset: beats must be ignored.
        begin
            int base;
            base = ev_n;
            send_frame(4, 4, 1'b0);
            idle(2);
            chk_cnt++;
            if (ev_n - base !== 0) $display("FAIL reset_unconfigured: got %0d windows want 0", ev_n - base);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_rate;
        int base;
        do_cfg(4, 4);
        base = ev_n;
        send_frame(4, 4, 1'b0);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 4) $display("FAIL full_count: got %0d want 4", ev_n - base);
        else pass_cnt++;
        chk_cnt++;
        if (ev_win[base] !== {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00})
            $display("FAIL full_first_win: got %h", ev_win[base]);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (ev_win[base+k] !== exp_win(2 + k/2, 2 + k%2))
                $display("FAIL full_win%0d: got %h want %h", k, ev_win[base+k], exp_win(2 + k/2, 2 + k%2));
            else pass_cnt++;
            chk_cnt++;
            if ({ev_sof[base+k], ev_eol[base+k], ev_eof[base+k]} !==
                {k == 0, k == 1 || k == 3, k == 3})
                $display("FAIL full_flags%0d: got %b want %b", k,
                         {ev_sof[base+k], ev_eol[base+k], ev_eof[base+k]},
                         {k == 0, k == 1 || k == 3, k == 3});
            else pass_cnt++;
        end
        chk_cnt++;
        if (ev_win[base+3][39:32] !== 8'h22) $display("FAIL full_centre: got %h want 22", ev_win[base+3][39:32]);
        else pass_cnt++;
    endtask

    task automatic test_toggle;
        int base;
        do_cfg(4, 4);
        base = ev_n;
        send_frame(4, 4, 1'b1);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 4) $display("FAIL toggle_count: got %0d want 4", ev_n - base);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (ev_win[base+k] !== exp_win(2 + k/2, 2 + k%2))
                $display("FAIL toggle_win%0d: got %h want %h", k, ev_win[base+k], exp_win(2 + k/2, 2 + k%2));
            else pass_cnt++;
            chk_cnt++;
            if ({ev_sof[base+k], ev_eol[base+k], ev_eof[base+k]} !==
                {k == 0, k == 1 || k == 3, k == 3})
                $display("FAIL toggle_flags%0d: got %b", k, {ev_sof[base+k], ev_eol[base+k], ev_eof[base+k]});
            else pass_cnt++;
            chk_cnt++;
            if (ev_cyc[base+k] !== exp_cyc[k])
                $display("FAIL toggle_latency%0d: got cycle %0d want %0d", k, ev_cyc[base+k], exp_cyc[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int base;
        do_cfg(5, 3);
        base = ev_n;
        send_frame(3, 5, 1'b0);
        send_frame(3, 5, 1'b0);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 6) $display("FAIL b2b_count: got %0d want 6", ev_n - base);
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            chk_cnt++;
            if (ev_win[base+k] !== exp_win(2, 2 + k%3))
                $display("FAIL b2b_win%0d: got %h want %h", k, ev_win[base+k], exp_win(2, 2 + k%3));
            else pass_cnt++;
            chk_cnt++;
            if ({ev_sof[base+k], ev_eol[base+k], ev_eof[base+k]} !==
                {k % 3 == 0, k % 3 == 2, k % 3 == 2})
                $display("FAIL b2b_flags%0d: got %b", k, {ev_sof[base+k], ev_eol[base+k], ev_eof[base+k]});
            else pass_cnt++;
        end
    endtask

    task automatic test_bad_cfg;
        int base;
        do_cfg(2, 8);
        chk_cnt++;
        if (cfg_err !== 1'b1) $display("FAIL bad_cfg_err: got %b want 1", cfg_err);
        else pass_cnt++;
        base = ev_n;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, i / 2, i % 2);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 0) $display("FAIL bad_cfg_idle: got %0d windows want 0", ev_n - base);
        else pass_cnt++;
        do_cfg(3, 3);
        chk_cnt++;
        if (cfg_err !== 1'b0) $display("FAIL min_cfg_err: got %b want 0", cfg_err);
        else pass_cnt++;
        base = ev_n;
        send_frame(3, 3, 1'b0);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 1) $display("FAIL min_count: got %0d want 1", ev_n - base);
        else pass_cnt++;
        chk_cnt++;
        if ({ev_sof[base], ev_eol[base], ev_eof[base]} !== 3'b111)
            $display("FAIL min_flags: got %b want 111", {ev_sof[base], ev_eol[base], ev_eof[base]});
        else pass_cnt++;
        chk_cnt++;
        if (ev_win[base] !== exp_win(2, 2)) $display("FAIL min_win: got %h want %h", ev_win[base], exp_win(2, 2));
        else pass_cnt++;
    endtask

    task automatic test_cfg_collision;
        int base;
        do_cfg(4, 4);
        base = ev_n;
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, i / 4, i % 4);
        cfg_cols = 12'd4;
        cfg_rows = 12'd4;
        drive(1'b1, 1'b1, 2, 1);
        chk_cnt++;
        if (dn_val !== 1'b0) $display("FAIL collide_dn_val: got %b want 0", dn_val);
        else pass_cnt++;
        send_frame(4, 4, 1'b0);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 4) $display("FAIL collide_count: got %0d want 4", ev_n - base);
        else pass_cnt++;
        chk_cnt++;
        if (ev_cyc[base] !== exp_cyc[0])
            $display("FAIL collide_first_cycle: got %0d want %0d", ev_cyc[base], exp_cyc[0]);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (ev_win[base+k] !== exp_win(2 + k/2, 2 + k%2))
                $display("FAIL collide_win%0d: got %h want %h", k, ev_win[base+k], exp_win(2 + k/2, 2 + k%2));
            else pass_cnt++;
        end
        chk_cnt++;
        if (ev_sof[base] !== 1'b1) $display("FAIL collide_sof: got %b want 1", ev_sof[base]);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        int base;
        do_cfg(4, 4);
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, i / 4, i % 4);
        chk_cnt++;
        if (dn_val !== 1'b1) $display("FAIL pre_reset_dn_val: got %b want 1", dn_val);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++;
        if ({dn_val, dn_sof, dn_eol, dn_eof, cfg_err} !== 5'b0)
            $display("FAIL async_flags: got %b want 00000", {dn_val, dn_sof, dn_eol, dn_eof, cfg_err});
        else pass_cnt++;
        chk_cnt++;
        if (dn_win !== 72'h0) $display("FAIL async_win: got %h want 0", dn_win);
        else pass_cnt++;
        #1 rst = 1'b1;
        base = ev_n;
        send_frame(4, 4, 1'b0);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 0) $display("FAIL post_reset_idle: got %0d windows want 0", ev_n - base);
        else pass_cnt++;
        do_cfg(4, 4);
        base = ev_n;
        send_frame(4, 4, 1'b0);
        idle(2);
        chk_cnt++;
        if (ev_n - base !== 4) $display("FAIL post_reset_count: got %0d want 4", ev_n - base);
        else pass_cnt++;
        chk_cnt++;
        if (ev_win[base] !== exp_win(2, 2)) $display("FAIL post_reset_win: got %h want %h", ev_win[base], exp_win(2, 2));
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        test_full_rate();
        test_toggle();
        test_back_to_back();
        test_bad_cfg();
        test_cfg_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
